// File: rtl/mem_access_seq.sv
// SRAM access sequencer: turns single-word read/write requests into timed, active-low SRAM strobe sequences.
// Optional `MEM_ACCESS_STAT_EN adds saturating read/write completion counters (Rd_Count, Wr_Count).
module mem_access_seq #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req_Read,
   input  logic        Req_Write,
   input  logic [15:0] Addr,
   input  logic [15:0] Wdata,
   output logic [15:0] Rdata,
   output logic        Busy,
   output logic        Done,
   output logic [19:0] ADDR,
   output logic        Mem_CE,
   output logic        Mem_OE,
   output logic        Mem_WE,
   output logic        Mem_UB,
   output logic        Mem_LB,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        Drive_En
`ifdef MEM_ACCESS_STAT_EN
   ,
   output logic [15:0] Rd_Count,
   output logic [15:0] Wr_Count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        is_write, is_write_nxt;
   logic [3:0]  wait_cnt;
   logic [15:0] addr_q;

   logic ce_nxt, oe_nxt, we_nxt, bs_nxt, de_nxt, busy_nxt, done_nxt;

   // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt    = state;
      is_write_nxt = is_write;
      case (state)
         S_IDLE: begin
            if (Req_Write || Req_Read) begin
               state_nxt    = S_SETUP;
               is_write_nxt = Req_Write;
            end
         end
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: if (wait_cnt == 4'd0) state_nxt = S_HOLD;
         S_HOLD:   state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Pin values are decoded from the upcoming state and then registered, keeping Req_* off the SRAM pins.
   always_comb begin
      ce_nxt   = 1'b1;
      oe_nxt   = 1'b1;
      we_nxt   = 1'b1;
      bs_nxt   = 1'b1;
      de_nxt   = 1'b0;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         S_SETUP: begin
            ce_nxt   = 1'b0;
            bs_nxt   = 1'b0;
            busy_nxt = 1'b1;
            if (is_write_nxt) de_nxt = 1'b1;
            else              oe_nxt = 1'b0;
         end
         S_ACCESS: begin
            ce_nxt   = 1'b0;
            bs_nxt   = 1'b0;
            busy_nxt = 1'b1;
            if (is_write_nxt) begin
               we_nxt = 1'b0;
               de_nxt = 1'b1;
            end else begin
               oe_nxt = 1'b0;
            end
         end
         S_HOLD: begin
            ce_nxt   = 1'b0;
            bs_nxt   = 1'b0;
            busy_nxt = 1'b1;
            de_nxt   = is_write_nxt;
         end
         S_DONE: begin
            busy_nxt = 1'b1;
            done_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments and every register here has an async reset value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= S_IDLE;
         is_write     <= 1'b0;
         wait_cnt     <= 4'd0;
         addr_q       <= 16'h0000;
         Data_to_SRAM <= 16'h0000;
         Rdata        <= 16'h0000;
         Mem_CE       <= 1'b1;
         Mem_OE       <= 1'b1;
         Mem_WE       <= 1'b1;
         Mem_UB       <= 1'b1;
         Mem_LB       <= 1'b1;
         Drive_En     <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
      end else begin
         state    <= state_nxt;
         is_write <= is_write_nxt;
         Mem_CE   <= ce_nxt;
         Mem_OE   <= oe_nxt;
         Mem_WE   <= we_nxt;
         Mem_UB   <= bs_nxt;
         Mem_LB   <= bs_nxt;
         Drive_En <= de_nxt;
         Busy     <= busy_nxt;
         Done     <= done_nxt;

         if (state == S_IDLE && (Req_Write || Req_Read)) begin
            addr_q       <= Addr;
            Data_to_SRAM <= Wdata;
         end

         if (state == S_SETUP) begin
            wait_cnt <= WAIT_LOAD;
         end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         // Read data is sampled on the edge that closes the last strobed cycle.
         if (state == S_ACCESS && wait_cnt == 4'd0 && !is_write) begin
            Rdata <= Data_from_SRAM;
         end
      end
   end

   assign ADDR = {4'b0000, addr_q};

`ifdef MEM_ACCESS_STAT_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Rd_Count <= 16'h0000;
         Wr_Count <= 16'h0000;
      end else if (state == S_DONE) begin
         if (is_write) begin
            if (Wr_Count != 16'hFFFF) Wr_Count <= Wr_Count + 16'd1;
         end else begin
            if (Rd_Count != 16'hFFFF) Rd_Count <= Rd_Count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: SRAM model plus a transaction-level reference of
// memory contents, latency and per-access strobe cycle counts; random traffic on top of directed cases.
module tb_mem_access_seq;

   localparam int W = 2;

   logic        Clk, Reset;
   logic        Req_Read, Req_Write;
   logic [15:0] Addr, Wdata, Rdata;
   logic        Busy, Done;
   logic [19:0] ADDR;
   logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
   logic [15:0] Data_to_SRAM, Data_from_SRAM;
   logic        Drive_En;
`ifdef MEM_ACCESS_STAT_EN
   logic [15:0] Rd_Count, Wr_Count;
`endif

   mem_access_seq #(.WAIT_CYCLES(W)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req_Read(Req_Read), .Req_Write(Req_Write),
      .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata),
      .Busy(Busy), .Done(Done), .ADDR(ADDR),
      .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
      .Drive_En(Drive_En)
`ifdef MEM_ACCESS_STAT_EN
      , .Rd_Count(Rd_Count), .Wr_Count(Wr_Count)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // SRAM model: combinational read while selected, write sampled at each clock edge with WE low.
   logic [15:0] sram [0:65535];
   assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? sram[ADDR[15:0]] : 16'h0000;
   always @(posedge Clk) begin
      if (!Mem_CE && !Mem_WE && Drive_En) sram[ADDR[15:0]] = Data_to_SRAM;
   end

   // Reference: expected memory contents are the fill pattern unless a completed write replaced them.
   logic [15:0] ref_wr [logic [15:0]];
   logic [15:0] exp_rdata;
   int          n_rd, n_wr;

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      if (ref_wr.exists(a)) return ref_wr[a];
      return a ^ 16'h5A5A;
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int viol = 0;
   always @(negedge Clk) begin
      if (!Mem_WE && !Mem_OE) viol++;
      if (Drive_En && !Mem_OE) viol++;
   end

   // One access from IDLE; pulse_cyc != 0 raises Req_Read for exactly one sampling edge in that cycle.
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] wd, input int pulse_cyc);
      int   oe_lo = 0, we_lo = 0, de_hi = 0, busy_hi = 0, n_done = 0, done_at = -1;
      logic addr_ok = 1'b1;
      @(negedge Clk);
      Req_Read = rd; Req_Write = wr; Addr = a; Wdata = wd;
      @(posedge Clk);
      #1;
      Req_Read = 1'b0; Req_Write = 1'b0; Addr = 16'($urandom); Wdata = 16'($urandom);
      for (int c = 1; c <= 2 * W + 8; c++) begin
         @(negedge Clk);
         if (!Mem_OE)  oe_lo++;
         if (!Mem_WE)  we_lo++;
         if (Drive_En) de_hi++;
         if (Busy)     busy_hi++;
         if (Done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         if (!Mem_CE && ADDR !== {4'h0, a}) addr_ok = 1'b0;
         if (pulse_cyc != 0 && c == pulse_cyc)     Req_Read = 1'b1;
         if (pulse_cyc != 0 && c == pulse_cyc + 1) Req_Read = 1'b0;
      end
      check($sformatf("%s_done_at", tag), done_at, W + 3);
      check($sformatf("%s_n_done", tag), n_done, 1);
      check($sformatf("%s_busy_cycles", tag), busy_hi, W + 3);
      check($sformatf("%s_oe_cycles", tag), oe_lo, wr ? 0 : W + 1);
      check($sformatf("%s_we_cycles", tag), we_lo, wr ? W : 0);
      check($sformatf("%s_drive_cycles", tag), de_hi, wr ? W + 2 : 0);
      check($sformatf("%s_addr_stable", tag), addr_ok, 1);
      check($sformatf("%s_addr", tag), ADDR, {4'h0, a});
      if (wr) begin
         ref_wr[a] = wd;
         n_wr++;
         check($sformatf("%s_sram", tag), sram[a], wd);
      end else begin
         exp_rdata = ref_read(a);
         n_rd++;
      end
      check($sformatf("%s_rdata", tag), Rdata, exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done1, done2;
      Reset = 1'b1; Req_Read = 1'b0; Req_Write = 1'b0; Addr = 16'h0; Wdata = 16'h0;
      for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'h5A5A;
      sram[16'h0012] = 16'hBEEF;
      ref_wr[16'h0012] = 16'hBEEF;
      exp_rdata = 16'h0000;
      n_rd = 0; n_wr = 0;

      #12;
      check("rst_strobes", {Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}, 5'h1F);
      check("rst_ctrl", {Drive_En, Done, Busy}, 3'b000);
      check("rst_rdata", Rdata, 16'h0000);
      check("rst_addr", ADDR, 20'h00000);
      check("rst_wdata", Data_to_SRAM, 16'h0000);
      @(negedge Clk);
      Reset = 1'b0;

      run_access("rd_beef", 1'b1, 1'b0, 16'h0012, 16'h0000, 0);
      run_access("wr_3000", 1'b0, 1'b1, 16'h3000, 16'h1234, 0);
      run_access("both", 1'b1, 1'b1, 16'h3001, 16'hA5C3, 0);
      run_access("wr_pulse", 1'b0, 1'b1, 16'h3002, 16'h0F0F, 2);

      // Request held through DONE starts the next access right after the IDLE cycle.
      @(negedge Clk);
      Req_Read = 1'b1; Addr = 16'h0012;
      done1 = -1;
      for (int c = 1; c <= 20 && done1 < 0; c++) begin
         @(negedge Clk);
         if (Done) done1 = c;
      end
      check("hold_done1", done1, W + 3);
      @(negedge Clk);
      check("hold_idle_busy", Busy, 0);
      @(negedge Clk);
      check("hold_restart", {Busy, Mem_OE}, 2'b10);
      Req_Read = 1'b0;
      done2 = -1;
      for (int c = 1; c <= 20 && done2 < 0; c++) begin
         @(negedge Clk);
         if (Done) done2 = c;
      end
      check("hold_gap", done2 + 2, W + 4);
      exp_rdata = 16'hBEEF;
      n_rd += 2;
      check("hold_rdata", Rdata, exp_rdata);

      // Reset asserted in the ACCESS phase of a write.
      @(negedge Clk);
      Req_Write = 1'b1; Addr = 16'h0040; Wdata = 16'hDEAD;
      @(posedge Clk);
      #1 Req_Write = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("abort_we_low", Mem_WE, 0);
      Reset = 1'b1;
      #1;
      check("abort_strobes", {Mem_WE, Mem_CE, Drive_En}, 3'b110);
      check("abort_done_busy", {Done, Busy}, 2'b00);
      exp_rdata = 16'h0000;
      n_rd = 0; n_wr = 0;
      check("abort_rdata", Rdata, exp_rdata);
      @(negedge Clk);
      Reset = 1'b0;
      check("abort_no_write", sram[16'h0040], 16'h0040 ^ 16'h5A5A);
      run_access("post_rst_rd", 1'b1, 1'b0, 16'h0000, 16'h0000, 0);

      for (int i = 0; i < 16; i++) begin
         int unsigned kind;
         logic [15:0] a;
         kind = $urandom_range(0, 2);
         a = 16'h0100 | 16'($urandom_range(0, 15));
         run_access($sformatf("rnd%0d", i), kind != 1, kind != 0, a, 16'($urandom), 0);
      end

`ifdef MEM_ACCESS_STAT_EN
      check("stat_rd", Rd_Count, n_rd);
      check("stat_wr", Wr_Count, n_wr);
      @(negedge Clk);
      force dut.Rd_Count = 16'hFFFF;
      #1 release dut.Rd_Count;
      run_access("sat_rd", 1'b1, 1'b0, 16'h0012, 16'h0000, 0);
      check("stat_rd_sat", Rd_Count, 16'hFFFF);
      check("stat_wr_after_sat", Wr_Count, n_wr);
`endif

      check("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

SRAM access sequencer sitting between the SLC-3 datapath (MAR/MDR and the state controller) and the external 1Mx16 SRAM tristate interface. It accepts single-word read or write requests, drives the active-low SRAM strobes through fixed setup/access/hold phases with a configurable wait-state count, captures read data, and returns a one-cycle `Done` pulse. This makes memory latency explicit and handshaked, so the controller no longer relies on hard-coded wait states.

## Interface
Parameters:
- `WAIT_CYCLES`, 2, number of ACCESS-phase cycles with strobes asserted; legal range 1..15.

Ports:
- `Clk`  in  1  system clock, all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Req_Read`  in  1  read request, sampled only in IDLE.
- `Req_Write`  in  1  write request, sampled only in IDLE.
- `Addr`  in  16  word address (from MAR), latched at request acceptance.
- `Wdata`  in  16  write data (from MDR), latched at request acceptance.
- `Rdata`  out  16  captured read data, held until the next read completes.
- `Busy`  out  1  high from the cycle after acceptance through the DONE state.
- `Done`  out  1  one-cycle completion pulse.
- `ADDR`  out  20  SRAM address, `{4'b0000, latched Addr}`.
- `Mem_CE`, `Mem_OE`, `Mem_WE`, `Mem_UB`, `Mem_LB`  out  1 each  active-low SRAM strobes.
- `Data_to_SRAM`  out  16  latched write data.
- `Data_from_SRAM`  in  16  read data from tristate buffer.
- `Drive_En`  out  1  tristate output enable toward SRAM data pins.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, DONE. A 4-bit wait counter is used in ACCESS.
- IDLE: if `Req_Write` or `Req_Read` is high, latch `Addr`/`Wdata`, record the direction, and go to SETUP. `Req_Write` has priority when both are high.
- SETUP, 1 cycle: `Mem_CE`=0, `Mem_UB`=`Mem_LB`=0, `ADDR` stable.
  - Read: `Mem_OE`=0.
  - Write: `Drive_En`=1, `Mem_WE` stays 1.
- ACCESS, `WAIT_CYCLES` cycles: counter loads `WAIT_CYCLES-1` and decrements.
  - Read: `Mem_OE`=0. On the edge leaving the final ACCESS cycle, `Rdata` <= `Data_from_SRAM`.
  - Write: `Mem_WE`=0, `Drive_En`=1.
- HOLD, 1 cycle: `Mem_WE`=1 and `Mem_OE`=1. `Mem_CE`=0 and `ADDR` stay stable. `Drive_En` stays 1 for writes (data hold).
- DONE, 1 cycle: all strobes high, `Drive_En`=0, `Done`=1, `Busy`=1. Next state is IDLE.
- Requests seen outside IDLE are ignored, not queued. A request held high in the DONE cycle is accepted in the following IDLE cycle.
- `Mem_WE` and `Mem_OE` are never both low. `Drive_En` is never high while `Mem_OE`=0.
- `Rdata` does not change on writes.

## Timing
- Reset values: state IDLE; `Mem_CE`=`Mem_OE`=`Mem_WE`=`Mem_UB`=`Mem_LB`=1; `Drive_En`=0; `Done`=0; `Busy`=0; `Rdata`=0; `ADDR`=0; `Data_to_SRAM`=0.
- Reset is asynchronous. Asserting it mid-operation deasserts all strobes and `Drive_En` immediately, with no `Done` pulse. The aborted access is lost.
- Latency: request sampled at edge N; `Done` is high during cycle N+`WAIT_CYCLES`+3. With the default, `Done` comes 5 cycles after acceptance.
- Back-to-back throughput: one access per `WAIT_CYCLES`+4 cycles.
- Strobe outputs are registered, so there are no combinational paths from `Req_*` to the SRAM pins.

## Configuration
- `MEM_ACCESS_STAT_EN` defined:
  - Adds outputs `Rd_Count[15:0]` and `Wr_Count[15:0]`.
  - Each counter increments in the DONE cycle of its access type and saturates at 16'hFFFF.
  - Both reset to 0.
- Not defined: the ports and logic are absent, and all other behaviour is identical.

## Test plan
- Reset, then read with `Addr`=16'h0012 and SRAM model returning 16'hBEEF:
  - `ADDR`=20'h00012.
  - `Mem_OE` low for 3 cycles.
  - `Done` pulses 5 cycles after acceptance.
  - `Rdata`=16'hBEEF and stays there afterwards.
- Write with `Addr`=16'h3000, `Wdata`=16'h1234:
  - `Mem_WE` low for exactly 2 cycles.
  - `Drive_En` high for 4 cycles covering WE low.
  - SRAM model holds 16'h1234 at 0x3000.
  - `Rdata` unchanged.
- `Req_Read` and `Req_Write` both high in IDLE: a write is performed and `Mem_OE` never goes low.
- `Req_Read` pulsed during ACCESS of a write: ignored, with exactly one `Done`. `Req_Read` held through DONE: a second access starts the next cycle.
- Assert `Reset` during the ACCESS phase of a write:
  - `Mem_WE`, `Mem_CE` and `Drive_En` return inactive in the same cycle, with no `Done`.
  - After release, a read of 0x0000 completes normally.
- With `MEM_ACCESS_STAT_EN`, 3 reads and 2 writes give `Rd_Count`=3 and `Wr_Count`=2. A counter forced to 16'hFFFF stays at 16'hFFFF after another access.
